calc_alu_sequencer: RTL and testbench

Initiator for the ALU's valid/ready operand and result handshakes. It consumes calculator tokens (number, operator, equals, clear) from the upstream input decoder and evaluates them left to right in immediate-execution style, so "3+4*2=" gives 14. It holds the accumulator and pending operator, issues one ALU transaction per operator/number pair, and drives the display-facing value, error flag and update strobe.

---
 rtl/calc_alu_sequencer_if.sv | 61 ++++++
 rtl/calc_alu_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_calc_alu_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// calc_alu_sequencer_if
//   Bundles the token stream from the input decoder, the ALU operand/result
//   handshakes and the display outputs of calc_alu_sequencer.
//
//   master : the sequencer's view (drives o_* signals)
//   slave  : the environment's view (decoder, ALU, display)
//
//   Token side   : i_tok_valid, o_tok_ready, i_tok_type, i_tok_value,
//                  i_tok_op, i_signed
//   ALU operand  : o_alu_input_a/b/op/signed, o_alu_input_valid,
//                  i_alu_input_ready
//   ALU result   : i_alu_result, i_alu_error, i_alu_result_valid,
//                  o_alu_result_ready
//   Display      : o_disp_value, o_disp_error, o_disp_update, o_busy
// ---------------------------------------------------------------------------
interface calc_alu_sequencer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  i_tok_valid;
    logic                  o_tok_ready;
    logic [1:0]            i_tok_type;
    logic [DATA_WIDTH-1:0] i_tok_value;
    logic [1:0]            i_tok_op;
    logic                  i_signed;

    logic [DATA_WIDTH-1:0] o_alu_input_a;
    logic [DATA_WIDTH-1:0] o_alu_input_b;
    logic [1:0]            o_alu_input_op;
    logic                  o_alu_input_signed;
    logic                  o_alu_input_valid;
    logic                  i_alu_input_ready;

    logic [DATA_WIDTH-1:0] i_alu_result;
    logic                  i_alu_error;
    logic                  i_alu_result_valid;
    logic                  o_alu_result_ready;

    logic [DATA_WIDTH-1:0] o_disp_value;
    logic                  o_disp_error;
    logic                  o_disp_update;
    logic                  o_busy;

    modport master (
        input  i_tok_valid, i_tok_type, i_tok_value, i_tok_op, i_signed,
        input  i_alu_input_ready, i_alu_result, i_alu_error, i_alu_result_valid,
        output o_tok_ready,
        output o_alu_input_a, o_alu_input_b, o_alu_input_op, o_alu_input_signed,
        output o_alu_input_valid, o_alu_result_ready,
        output o_disp_value, o_disp_error, o_disp_update, o_busy
    );

    modport slave (
        output i_tok_valid, i_tok_type, i_tok_value, i_tok_op, i_signed,
        output i_alu_input_ready, i_alu_result, i_alu_error, i_alu_result_valid,
        input  o_tok_ready,
        input  o_alu_input_a, o_alu_input_b, o_alu_input_op, o_alu_input_signed,
        input  o_alu_input_valid, o_alu_result_ready,
        input  o_disp_value, o_disp_error, o_disp_update, o_busy
    );
endinterface

// File: rtl/calc_alu_sequencer.sv
// ---------------------------------------------------------------------------
// calc_alu_sequencer
//   Immediate-execution calculator sequencer. Consumes number/operator/
//   equals/clear tokens, keeps the accumulator and pending operator, and
//   issues one ALU transaction per operator/number pair ("3+4*2=" -> 14).
//
//   Ports:
//     clk  - system clock
//     rst  - synchronous active-high reset
//     bus  - calc_alu_sequencer_if.master (token, ALU and display signals)
//
//   Optional feature macro: CALC_SEQ_TIMEOUT_EN
//     Defined   : watchdog of TIMEOUT_CYCLES per ALU transaction; expiry
//                 moves to S_ERR with the error flag set.
//     Undefined : no watchdog, the sequencer waits for the ALU indefinitely.
// ---------------------------------------------------------------------------
module calc_alu_sequencer #(
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                 clk,
    input logic                 rst,
    calc_alu_sequencer_if.master bus
);
    typedef enum logic [1:0] {S_WAIT, S_ISSUE, S_RESULT, S_ERR} state_t;

    localparam logic [1:0] TOK_NUM = 2'b00;
    localparam logic [1:0] TOK_OP  = 2'b01;
    localparam logic [1:0] TOK_EQ  = 2'b10;
    localparam logic [1:0] TOK_CLR = 2'b11;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [1:0]            pend_op_q, pend_op_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [1:0]            op_q, op_d;
    logic                  signed_q, signed_d;
    logic                  error_q, error_d;
    logic                  update_q, update_d;

    logic tok_fire;
    logic busy;

`ifdef CALC_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    // Parameter kept so both builds share one instantiation template.
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
`endif

    // Ready is forced low while rst is held so no token slips in during reset.
    assign bus.o_tok_ready        = !rst && (state_q == S_WAIT || state_q == S_ERR);
    assign bus.o_alu_input_valid  = (state_q == S_ISSUE);
    assign bus.o_alu_result_ready = (state_q == S_RESULT || state_q == S_ERR);
    assign bus.o_alu_input_a      = a_q;
    assign bus.o_alu_input_b      = b_q;
    assign bus.o_alu_input_op     = op_q;
    assign bus.o_alu_input_signed = signed_q;
    assign bus.o_disp_value       = acc_q;
    assign bus.o_disp_error       = error_q;
    assign bus.o_disp_update      = update_q;
    assign busy                   = (state_q == S_ISSUE || state_q == S_RESULT);
    assign bus.o_busy             = busy;

    assign tok_fire = bus.i_tok_valid && bus.o_tok_ready;

    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        pend_valid_d = pend_valid_q;
        pend_op_d    = pend_op_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        signed_d     = signed_q;
        error_d      = error_q;
        update_d     = 1'b0;

        case (state_q)
            S_WAIT: begin
                if (tok_fire) begin
                    case (bus.i_tok_type)
                        TOK_NUM: begin
                            if (pend_valid_q) begin
                                a_d      = acc_q;
                                b_d      = bus.i_tok_value;
                                op_d     = pend_op_q;
                                signed_d = bus.i_signed;
                                state_d  = S_ISSUE;
                            end else begin
                                acc_d    = bus.i_tok_value;
                                update_d = 1'b1;
                            end
                        end
                        TOK_OP: begin
                            pend_op_d    = bus.i_tok_op;
                            pend_valid_d = 1'b1;
                        end
                        TOK_EQ: begin
                            pend_valid_d = 1'b0;
                            update_d     = 1'b1;
                        end
                        default: begin // TOK_CLR
                            acc_d        = '0;
                            pend_valid_d = 1'b0;
                            error_d      = 1'b0;
                            update_d     = 1'b1;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                if (bus.i_alu_input_ready) state_d = S_RESULT;
            end
            S_RESULT: begin
                if (bus.i_alu_result_valid) begin
                    update_d = 1'b1;
                    if (bus.i_alu_error) begin
                        error_d = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        acc_d        = bus.i_alu_result;
                        pend_valid_d = 1'b0;
                        state_d      = S_WAIT;
                    end
                end
            end
            default: begin // S_ERR: everything but CLEAR is swallowed
                if (tok_fire && bus.i_tok_type == TOK_CLR) begin
                    acc_d        = '0;
                    pend_valid_d = 1'b0;
                    error_d      = 1'b0;
                    update_d     = 1'b1;
                    state_d      = S_WAIT;
                end
            end
        endcase

`ifdef CALC_SEQ_TIMEOUT_EN
        // Counter is zero in S_WAIT, so it reads 0 on the first S_ISSUE cycle.
        cnt_d = busy ? cnt_q + 1'b1 : '0;
        if (busy && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1) &&
            !(state_q == S_RESULT && bus.i_alu_result_valid)) begin
            state_d  = S_ERR;
            error_d  = 1'b1;
            update_d = 1'b1;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_WAIT;
            acc_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_op_q    <= 2'b00;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= 2'b00;
            signed_q     <= 1'b0;
            error_q      <= 1'b0;
            update_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            pend_valid_q <= pend_valid_d;
            pend_op_q    <= pend_op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            signed_q     <= signed_d;
            error_q      <= error_d;
            update_q     <= update_d;
        end
    end

`ifdef CALC_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

endmodule

// File: tb/tb_calc_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_calc_alu_sequencer
//   Directed bench for calc_alu_sequencer. Plays the decoder and the ALU,
//   with every ALU result supplied as a hand-computed constant.
// ---------------------------------------------------------------------------
module tb_calc_alu_sequencer;
    localparam int DW = 16;
`ifdef CALC_SEQ_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    localparam logic [1:0] T_NUM = 2'b00, T_OP = 2'b01, T_EQ = 2'b10, T_CLR = 2'b11;
    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, DIV = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    calc_alu_sequencer_if #(.DATA_WIDTH(DW)) bus ();

    calc_alu_sequencer #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int upd_cnt  = 0;
    int alu_cnt  = 0;

    always @(posedge clk) begin
        if (bus.o_disp_update) upd_cnt <= upd_cnt + 1;
        if (bus.o_alu_input_valid && bus.i_alu_input_ready) alu_cnt <= alu_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_tok(input logic [1:0] t, input logic [DW-1:0] v, input logic [1:0] op);
        int n = 0;
        bus.i_tok_valid = 1'b1;
        bus.i_tok_type  = t;
        bus.i_tok_value = v;
        bus.i_tok_op    = op;
        while (!bus.o_tok_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("tok_ready_timeout", 32'd0, 32'd1);
        tick();
        bus.i_tok_valid = 1'b0;
    endtask

    // Waits for an ALU request, checks its operands, stalls ready for `stall`
    // cycles, then returns `res`/`err` as the ALU result.
    task automatic alu_txn(input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                           input logic [1:0] eop, input logic es, input int stall,
                           input logic [DW-1:0] res, input logic err);
        int n = 0;
        while (!bus.o_alu_input_valid && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            check("alu_valid_timeout", 32'd0, 32'd1);
            return;
        end
        check("alu_a", bus.o_alu_input_a, ea);
        check("alu_b", bus.o_alu_input_b, eb);
        check("alu_op", bus.o_alu_input_op, eop);
        check("alu_signed", bus.o_alu_input_signed, es);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_valid", bus.o_alu_input_valid, 1);
            check("stall_a", bus.o_alu_input_a, ea);
            check("stall_b", bus.o_alu_input_b, eb);
            check("stall_op", bus.o_alu_input_op, eop);
            check("stall_signed", bus.o_alu_input_signed, es);
            check("stall_tok_ready", bus.o_tok_ready, 0);
        end
        bus.i_alu_input_ready = 1'b1;
        tick();
        bus.i_alu_input_ready = 1'b0;
        check("result_valid_dropped", bus.o_alu_input_valid, 0);
        check("result_busy", bus.o_busy, 1);
        check("result_tok_ready", bus.o_tok_ready, 0);
        bus.i_alu_result       = res;
        bus.i_alu_error        = err;
        bus.i_alu_result_valid = 1'b1;
        tick();
        bus.i_alu_result_valid = 1'b0;
        bus.i_alu_error        = 1'b0;
    endtask

    int u0;
    int a0;
    int vcyc;

    initial begin
        bus.i_tok_valid        = 1'b0;
        bus.i_tok_type         = T_NUM;
        bus.i_tok_value        = '0;
        bus.i_tok_op           = ADD;
        bus.i_signed           = 1'b0;
        bus.i_alu_input_ready  = 1'b0;
        bus.i_alu_result       = '0;
        bus.i_alu_error        = 1'b0;
        bus.i_alu_result_valid = 1'b0;

        // Reset state
        tick(2);
        check("rst_tok_ready", bus.o_tok_ready, 0);
        check("rst_valid", bus.o_alu_input_valid, 0);
        check("rst_res_ready", bus.o_alu_result_ready, 0);
        check("rst_disp", bus.o_disp_value, 0);
        check("rst_err", bus.o_disp_error, 0);
        check("rst_upd", bus.o_disp_update, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_alu_a", bus.o_alu_input_a, 0);
        rst = 1'b0;
        tick();
        check("idle_tok_ready", bus.o_tok_ready, 1);

        // 3 + 4 = -> 7
        send_tok(T_NUM, 16'd3, ADD);
        check("t1_update_pulse", bus.o_disp_update, 1);
        tick();
        check("t1_update_single", bus.o_disp_update, 0);
        check("t1_acc3", bus.o_disp_value, 3);
        send_tok(T_OP, '0, ADD);
        send_tok(T_NUM, 16'd4, ADD);
        check("t1_busy", bus.o_busy, 1);
        check("t1_issue_latency", bus.o_alu_input_valid, 1);
        u0 = upd_cnt;
        alu_txn(16'd3, 16'd4, ADD, 1'b0, 0, 16'd7, 1'b0);
        tick(2);
        check("t1_res_upd", upd_cnt - u0, 1);
        check("t1_val7", bus.o_disp_value, 7);
        u0 = upd_cnt;
        send_tok(T_EQ, '0, ADD);
        tick(2);
        check("t1_eq_upd", upd_cnt - u0, 1);
        check("t1_eq_val7", bus.o_disp_value, 7);

        // 3 + 4 * 2 = -> 14
        send_tok(T_CLR, '0, ADD);
        send_tok(T_NUM, 16'd3, ADD);
        send_tok(T_OP, '0, ADD);
        send_tok(T_NUM, 16'd4, ADD);
        alu_txn(16'd3, 16'd4, ADD, 1'b0, 0, 16'd7, 1'b0);
        send_tok(T_OP, '0, MUL);
        send_tok(T_NUM, 16'd2, ADD);
        alu_txn(16'd7, 16'd2, MUL, 1'b0, 0, 16'd14, 1'b0);
        send_tok(T_EQ, '0, ADD);
        tick();
        check("t2_val14", bus.o_disp_value, 16'h000E);

        // 9 + - 2 = -> operator replacement, single SUB transaction
        send_tok(T_CLR, '0, ADD);
        a0 = alu_cnt;
        send_tok(T_NUM, 16'd9, ADD);
        send_tok(T_OP, '0, ADD);
        send_tok(T_OP, '0, SUB);
        send_tok(T_NUM, 16'd2, ADD);
        alu_txn(16'd9, 16'd2, SUB, 1'b0, 0, 16'd7, 1'b0);
        send_tok(T_EQ, '0, ADD);
        tick();
        check("t3_val7", bus.o_disp_value, 7);
        check("t3_one_txn", alu_cnt - a0, 1);

        // Second number overwrites the first; EQUALS does not repeat the op
        send_tok(T_NUM, 16'd5, ADD);
        send_tok(T_NUM, 16'd6, ADD);
        send_tok(T_EQ, '0, ADD);
        tick(2);
        check("ow_val6", bus.o_disp_value, 6);
        check("ow_no_txn", alu_cnt - a0, 1);

        // 5 / 0 -> error, S_ERR swallows tokens, CLEAR recovers
        send_tok(T_CLR, '0, ADD);
        send_tok(T_NUM, 16'd5, ADD);
        send_tok(T_OP, '0, DIV);
        send_tok(T_NUM, 16'd0, ADD);
        alu_txn(16'd5, 16'd0, DIV, 1'b0, 0, 16'hDEAD, 1'b1);
        check("t4_err", bus.o_disp_error, 1);
        check("t4_err_upd", bus.o_disp_update, 1);
        check("t4_acc_kept", bus.o_disp_value, 5);
        check("t4_err_tok_ready", bus.o_tok_ready, 1);
        check("t4_err_res_ready", bus.o_alu_result_ready, 1);
        check("t4_err_busy", bus.o_busy, 0);
        a0 = alu_cnt;
        send_tok(T_NUM, 16'd1, ADD);
        send_tok(T_OP, '0, ADD);
        tick(3);
        check("t4_no_alu_valid", bus.o_alu_input_valid, 0);
        check("t4_no_txn", alu_cnt - a0, 0);
        check("t4_val_still5", bus.o_disp_value, 5);
        bus.i_alu_result       = 16'h1234;
        bus.i_alu_result_valid = 1'b1;
        tick();
        bus.i_alu_result_valid = 1'b0;
        tick();
        check("t4_stray_ignored", bus.o_disp_value, 5);
        check("t4_still_err", bus.o_disp_error, 1);
        send_tok(T_CLR, '0, ADD);
        check("t4_clr_val", bus.o_disp_value, 0);
        check("t4_clr_err", bus.o_disp_error, 0);
        check("t4_clr_res_ready", bus.o_alu_result_ready, 0);

        // 0xFFFE * 3 signed with a 5-cycle operand stall -> 0xFFFA
        bus.i_signed = 1'b1;
        send_tok(T_NUM, 16'hFFFE, ADD);
        send_tok(T_OP, '0, MUL);
        send_tok(T_NUM, 16'd3, ADD);
        bus.i_signed = 1'b0;
        alu_txn(16'hFFFE, 16'd3, MUL, 1'b1, 5, 16'hFFFA, 1'b0);
        tick();
        check("t5_valFFFA", bus.o_disp_value, 16'hFFFA);
        check("t5_tok_ready_back", bus.o_tok_ready, 1);

        // Reset in the middle of a transaction
        send_tok(T_CLR, '0, ADD);
        send_tok(T_OP, '0, ADD);
        send_tok(T_NUM, 16'd1, ADD);
        tick(2);
        check("mid_valid_before_rst", bus.o_alu_input_valid, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", bus.o_alu_input_valid, 0);
        check("mid_rst_res_ready", bus.o_alu_result_ready, 0);
        check("mid_rst_busy", bus.o_busy, 0);
        check("mid_rst_tok_ready", bus.o_tok_ready, 0);
        check("mid_rst_alu_b", bus.o_alu_input_b, 0);
        check("mid_rst_disp", bus.o_disp_value, 0);
        rst = 1'b0;
        tick();

        // Watchdog (or its absence) with the ALU never ready
        send_tok(T_NUM, 16'd2, ADD);
        send_tok(T_OP, '0, ADD);
        send_tok(T_NUM, 16'd1, ADD);
`ifdef CALC_SEQ_TIMEOUT_EN
        vcyc = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.o_alu_input_valid) vcyc++;
            tick();
        end
        check("tmo_valid_cycles", vcyc, TMO);
        check("tmo_err", bus.o_disp_error, 1);
        check("tmo_res_ready", bus.o_alu_result_ready, 1);
        check("tmo_acc_kept", bus.o_disp_value, 2);
`else
        vcyc = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.o_alu_input_valid) vcyc++;
            tick();
        end
        check("wait_valid_cycles", vcyc, 100);
        check("wait_still_valid", bus.o_alu_input_valid, 1);
        check("wait_busy", bus.o_busy, 1);
        check("wait_no_err", bus.o_disp_error, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
